// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit in the execute stage.
// It computes one product or quotient bit per cycle. Every operation takes
// exactly 34 cycles from start to return to IDLE, including divide-by-zero
// and signed overflow.
//
// Handshake: start is sampled only in IDLE and is dropped when kill is
// asserted in the same cycle. busy is high from the edge that accepts start
// up to and including the done cycle. done pulses for one cycle, and MD_out
// is valid while it is high. MD_out holds its value until the next
// completion. kill returns the unit to IDLE at the next edge, produces no
// done pulse and leaves MD_out unchanged.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      MDSel,
    input  logic [XLEN-1:0] Data_A,
    input  logic [XLEN-1:0] Data_B,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] MD_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_raw_q, b_raw_q;
    logic [XLEN-1:0]   a_mag_q, b_mag_q;
    logic              neg_q;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: low half holds the dividend bits, which are shifted out while
    // quotient bits are shifted in.
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   rem_q;

    // Operand preparation at capture
    logic              a_signed, b_signed, a_neg, b_neg, capture;
    logic [XLEN-1:0]   a_mag, b_mag;

    // Per-iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;   // 33-bit working partial remainder
    logic              div_ge;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   q_next;

    // Fixup results
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
    logic              div_by_zero, sgn_ovf;

    // Decode operand signedness and magnitudes from the live inputs
    always_comb begin
        a_signed = (MDSel == 3'b001) || (MDSel == 3'b010) ||
                   (MDSel == 3'b100) || (MDSel == 3'b110);
        b_signed = (MDSel == 3'b001) || (MDSel == 3'b100) || (MDSel == 3'b110);
        a_neg    = a_signed && Data_A[XLEN-1];
        b_neg    = b_signed && Data_B[XLEN-1];
        a_mag    = a_neg ? (~Data_A + 1'b1) : Data_A;
        b_mag    = b_neg ? (~Data_B + 1'b1) : Data_B;
        capture  = (state_q == S_IDLE) && start && !kill;
    end

    // One shift-add step (LSB first) and one restoring-divide step (MSB first)
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, a_mag_q} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, b_mag_q});
        rem_next  = div_ge ? XLEN'(div_shift - {1'b0, b_mag_q})
                           : div_shift[XLEN-1:0];
        q_next    = {acc_q[XLEN-2:0], div_ge};
    end

    // Sign correction and the special cases that override the iterated result
    always_comb begin
        prod_fix    = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix     = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix     = neg_q ? (~rem_q + 1'b1) : rem_q;
        div_by_zero = (b_mag_q == '0);
        sgn_ovf     = !op_q[0] && (a_raw_q == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (b_raw_q == {XLEN{1'b1}});
        fix_res     = '0;
        if (!op_q[2]) begin
            fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                           : prod_fix[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            if (div_by_zero)  fix_res = {XLEN{1'b1}};
            else if (sgn_ovf) fix_res = {1'b1, {(XLEN-1){1'b0}}};
            else              fix_res = quo_fix;
        end else begin
            if (div_by_zero)  fix_res = a_raw_q;
            else if (sgn_ovf) fix_res = '0;
            else              fix_res = rem_fix;
        end
    end

    // Next-state logic; kill aborts from any non-IDLE state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !kill) state_d = S_CALC;
            S_CALC:  if (kill) state_d = S_IDLE;
                     else if (cnt_q == 5'd31) state_d = S_FIXUP;
            S_FIXUP: state_d = kill ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register with registered busy/done status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_DONE);
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_q    <= '0;
            a_raw_q <= '0;
            b_raw_q <= '0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            rem_q   <= '0;
            MD_out  <= '0;
        end else begin
            if (capture) begin
                cnt_q   <= '0;
                op_q    <= MDSel;
                a_raw_q <= Data_A;
                b_raw_q <= Data_B;
                a_mag_q <= a_mag;
                b_mag_q <= b_mag;
                neg_q   <= (MDSel[2] && MDSel[1]) ? a_neg : (a_neg ^ b_neg);
                acc_q   <= MDSel[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                rem_q   <= '0;
            end else if (state_q == S_CALC && !kill) begin
                cnt_q <= cnt_q + 5'd1;
                if (!op_q[2]) begin
                    acc_q <= mul_next;
                end else begin
                    acc_q <= {acc_q[2*XLEN-1:XLEN], q_next};
                    rem_q <= rem_next;
                end
            end
            if (state_q == S_FIXUP && !kill) begin
                MD_out <= fix_res;
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the same forwarded operands as the ALU (Data_A, Data_B). It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a fixed number of cycles and asserts `busy` so the hazard unit stalls the front end. The registered result is muxed into the writeback path in place of ALU_out on the `done` cycle.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- MDSel  input  3  operation, equal to instruction funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Data_A  input  32  rs1 operand (multiplicand / dividend).
- Data_B  input  32  rs2 operand (multiplier / divisor).
- kill  input  1  pipeline flush; aborts the operation in flight.
- busy  output  1  high from the cycle after start is accepted through the done cycle.
- done  output  1  one-cycle pulse; MD_out is valid.
- MD_out  output  32  result register; holds its value until the next completion.

## Operation
- States:
  - IDLE: `start` → CALC; operands, MDSel and sign flags are captured and the counter is cleared.
  - CALC: 32 iterations; after the 32nd iteration → FIXUP.
  - FIXUP: sign correction and special cases; MD_out is loaded → DONE.
  - DONE: done=1 → IDLE.
- Operand preparation at capture:
  - A is signed for MULH, MULHSU, DIV and REM.
  - B is signed for MULH, DIV and REM.
  - Signed negative operands are replaced by their two's-complement magnitude.
  - neg_res = sign(A) XOR sign(B) for products and quotients; sign(A) alone for remainders.
- Multiply: radix-2 shift-add on the 32-bit magnitudes into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - FIXUP negates the 64-bit product if neg_res.
  - MUL returns bits [31:0]; the other multiply ops return [63:32].
- Divide: restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial remainder; subtract if it does not go negative.
  - FIXUP negates the quotient or remainder if neg_res.
- Special cases, resolved in FIXUP with the same latency as normal operations:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return Data_A unchanged.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- `start` while not in IDLE is ignored; no queueing.
- `kill` in any non-IDLE state → IDLE at the next edge; no done; MD_out is unchanged.
- `kill` and `start` together in IDLE: the start is dropped.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, MD_out=0, counter=0, internal accumulators 0.
- Latency, with start sampled high at edge k:
  - CALC is entered at k; iterations occur on edges k+1..k+32.
  - FIXUP occurs at k+33; done=1 and MD_out is valid in the cycle after k+33.
  - The unit is back in IDLE at k+34.
  - Total 34 cycles per operation; the next start can be accepted at edge k+34.
- busy is registered: high from edge k to edge k+34, which includes the done cycle. It is low in IDLE.
- done is registered and high for exactly one cycle.
- Data_A, Data_B and MDSel may change freely after edge k, because all values are captured internally.
- Reset deasserted mid-operation has no effect on a finished state. Reset asserted at any point aborts immediately with no done pulse.

## Test plan
- MUL 0x00000007 × 0xFFFFFFFD → MD_out=0xFFFFFFEB. Also check: done exactly one cycle, 34 edges after start; busy high for 34 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 0x00000002 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 0xF0002323 / 0x12345678 → 0x0000000D.
- DIVU 0x64 / 0 → 0xFFFFFFFF; REMU 0x64 / 0 → 0x00000064. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0x00000000.
- start pulsed again at cycle 5 of an operation → ignored, and the original result is delivered. kill at cycle 10 → IDLE next cycle, no done, MD_out keeps its prior value.
- rst_n pulled low at cycle 20 of a DIV → busy=0, done=0 and MD_out=0 immediately, before the next clock edge. A new MUL issued after reset completes correctly.
